// File: rtl/fe_iq_if.sv
// Packet types and the fetch/decode handshake bundle for the fe_iq instruction queue.
// The queue drives the slave modport; the fetch/decode environment drives the master modport.
package fe_iq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } t_instr_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } t_nuke_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } t_br_mispred_pkt;

endpackage

interface fe_iq_if;

  logic                   valid_fe0;
  fe_iq_pkg::t_instr_pkt  instr_fe0;
  logic                   iq_ready_fe0;
  logic                   valid_fe1;
  fe_iq_pkg::t_instr_pkt  instr_fe1;
  logic                   decode_ready_de0;

  modport slave (
    input  valid_fe0,
    input  instr_fe0,
    input  decode_ready_de0,
    output iq_ready_fe0,
    output valid_fe1,
    output instr_fe1
  );

  modport master (
    output valid_fe0,
    output instr_fe0,
    output decode_ready_de0,
    input  iq_ready_fe0,
    input  valid_fe1,
    input  instr_fe1
  );

endinterface

// File: rtl/fe_iq.sv
// Fetch-to-decode instruction queue with flush on nuke or branch mispredict.
// Define IQ_BYPASS_EN to let fetch reach decode in the same cycle when the queue is empty.
module fe_iq
  import fe_iq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  fe_iq_if.slave            iq,
  input  t_nuke_pkt         nuke_rb1,
  input  t_br_mispred_pkt   br_mispred_ex0,
  output logic [PTR_W-1:0]  iq_count
);

  localparam int unsigned IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {IDX_W{1'b0}}};

  t_instr_pkt       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             flush, full, empty, enq, deq, bypass;

  always_comb begin
    flush           = nuke_rb1.valid | br_mispred_ex0.valid;
    full            = (wr_ptr_q ^ rd_ptr_q) == FULL_XOR;
    empty           = wr_ptr_q == rd_ptr_q;
    iq_count        = wr_ptr_q - rd_ptr_q;
    iq.iq_ready_fe0 = ~full;
`ifdef IQ_BYPASS_EN
    // Empty queue with decode ready: packet goes straight through, storage untouched.
    bypass          = empty & ~flush & iq.valid_fe0 & iq.decode_ready_de0;
    iq.valid_fe1    = (~empty | iq.valid_fe0) & ~flush;
    iq.instr_fe1    = empty ? iq.instr_fe0 : mem[rd_ptr_q[IDX_W-1:0]];
`else
    bypass          = 1'b0;
    iq.valid_fe1    = ~empty & ~flush;
    iq.instr_fe1    = mem[rd_ptr_q[IDX_W-1:0]];
`endif
    enq             = iq.valid_fe0 & ~full & ~flush & ~bypass;
    deq             = iq.valid_fe1 & iq.decode_ready_de0 & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is never cleared; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (reset && enq) mem[wr_ptr_q[IDX_W-1:0]] <= iq.instr_fe0;
  end

`ifdef ASSERT
  a_no_enq_full: assert property (@(posedge clk) disable iff (!reset) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset) !(deq && empty));
  a_count_max: assert property (@(posedge clk) disable iff (!reset) iq_count <= PTR_W'(DEPTH));
  a_fetch_stable: assert property (@(posedge clk) disable iff (!reset)
    (iq.valid_fe0 && !iq.iq_ready_fe0 && !flush) |=> (!iq.valid_fe0 || $stable(iq.instr_fe0)));
`endif

endmodule

// File: tb/tb_fe_iq.sv
// Randomized and directed bench for fe_iq against a queue-based reference model.
module tb_fe_iq;
  import fe_iq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  t_nuke_pkt        nuke;
  t_br_mispred_pkt  br;
  logic [PTR_W-1:0] iq_count;

  fe_iq_if bus ();

  fe_iq #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .iq             (bus),
    .nuke_rb1       (nuke),
    .br_mispred_ex0 (br),
    .iq_count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic t_instr_pkt mk(input int tag);
    t_instr_pkt p;
    p.pc   = 32'(tag);
    p.insn = $urandom;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of live entries, updated once per cycle.
  t_instr_pkt model_q[$];
  logic       m_flush, m_valid, m_ready, m_through;
  int         m_cnt;
  t_instr_pkt m_head;

  always @(negedge clk) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      m_flush = nuke.valid || br.valid;
      m_cnt   = model_q.size();
      m_ready = m_cnt != DEPTH;
`ifdef IQ_BYPASS_EN
      m_valid = (m_cnt != 0 || bus.valid_fe0) && !m_flush;
      m_head  = (m_cnt != 0) ? model_q[0] : bus.instr_fe0;
`else
      m_valid = (m_cnt != 0) && !m_flush;
      m_head  = (m_cnt != 0) ? model_q[0] : '0;
`endif
      chk("count", 64'(iq_count), 64'(m_cnt));
      chk("ready", 64'(bus.iq_ready_fe0), 64'(m_ready));
      chk("valid", 64'(bus.valid_fe1), 64'(m_valid));
      if (m_valid) chk("head", 64'(bus.instr_fe1), 64'(m_head));
      if (m_flush) begin
        model_q.delete();
      end else begin
        m_through = (m_cnt == 0) && m_valid && bus.decode_ready_de0;
        if (m_valid && bus.decode_ready_de0 && m_cnt != 0) void'(model_q.pop_front());
        if (bus.valid_fe0 && m_ready && !m_through) model_q.push_back(bus.instr_fe0);
      end
    end
  end

  task automatic flush_test(input bit use_br);
    bus.decode_ready_de0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.valid_fe0 = 1'b1;
      bus.instr_fe0 = mk(8'h40 + i);
    end
    tick();
    if (use_br) br.valid = 1'b1;
    else nuke.valid = 1'b1;
    bus.valid_fe0        = 1'b1;
    bus.instr_fe0        = mk(8'h4f);
    bus.decode_ready_de0 = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(bus.valid_fe1), 64'(0));
    chk("flush_count_pre", 64'(iq_count), 64'(3));
    tick();
    nuke.valid    = 1'b0;
    br.valid      = 1'b0;
    bus.valid_fe0 = 1'b0;
    @(negedge clk);
    chk("flush_count_post", 64'(iq_count), 64'(0));
    chk("flush_valid_post", 64'(bus.valid_fe1), 64'(0));
  endtask

  t_instr_pkt px, py;
  bit         hold;
  int         tag;

  initial begin
    reset                = 1'b0;
    nuke                 = '0;
    br                   = '0;
    bus.valid_fe0        = 1'b1;
    bus.instr_fe0        = mk(100);
    bus.decode_ready_de0 = 1'b0;
    repeat (3) tick();
    reset         = 1'b1;
    bus.valid_fe0 = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(iq_count), 64'(0));
    chk("rst_valid", 64'(bus.valid_fe1), 64'(0));
    chk("rst_ready", 64'(bus.iq_ready_fe0), 64'(1));

    // Fill with A..D under backpressure, E must wait.
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.valid_fe0 = 1'b1;
      bus.instr_fe0 = mk(8'ha0 + i);
    end
    @(negedge clk);
    chk("full_count", 64'(iq_count), 64'(4));
    chk("full_ready", 64'(bus.iq_ready_fe0), 64'(0));
    chk("full_head", 64'(bus.instr_fe1.pc), 64'(8'ha0));
    tick();
    bus.decode_ready_de0 = 1'b1;
    @(negedge clk);
    chk("nobypass_ready", 64'(bus.iq_ready_fe0), 64'(0));
    chk("deq_a", 64'(bus.instr_fe1.pc), 64'(8'ha0));
    tick();
    @(negedge clk);
    chk("e_accept_ready", 64'(bus.iq_ready_fe0), 64'(1));
    chk("deq_b", 64'(bus.instr_fe1.pc), 64'(8'ha1));
    tick();
    bus.valid_fe0 = 1'b0;
    @(negedge clk);
    chk("after_e_count", 64'(iq_count), 64'(3));
    chk("deq_c", 64'(bus.instr_fe1.pc), 64'(8'ha2));
    repeat (3) tick();
    @(negedge clk);
    chk("drain_count", 64'(iq_count), 64'(0));

    // Streaming: 20 packets back to back with decode always ready.
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.valid_fe0 = 1'b1;
      bus.instr_fe0 = mk(i);
      @(negedge clk);
`ifdef IQ_BYPASS_EN
      chk("stream_count", 64'(iq_count), 64'(0));
      chk("stream_head", 64'(bus.instr_fe1.pc), 64'(i));
`else
      if (i > 0) begin
        chk("stream_count", 64'(iq_count), 64'(1));
        chk("stream_head", 64'(bus.instr_fe1.pc), 64'(i - 1));
      end
`endif
    end
    tick();
    bus.valid_fe0 = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("stream_drain", 64'(iq_count), 64'(0));

    flush_test(1'b0);
    flush_test(1'b1);

`ifdef IQ_BYPASS_EN
    px = mk(8'h77);
    py = mk(8'h78);
    tick();
    bus.valid_fe0        = 1'b1;
    bus.instr_fe0        = px;
    bus.decode_ready_de0 = 1'b1;
    @(negedge clk);
    chk("byp_valid", 64'(bus.valid_fe1), 64'(1));
    chk("byp_instr", 64'(bus.instr_fe1), 64'(px));
    tick();
    bus.instr_fe0        = py;
    bus.decode_ready_de0 = 1'b0;
    @(negedge clk);
    chk("byp_count0", 64'(iq_count), 64'(0));
    chk("byp_instr_y", 64'(bus.instr_fe1), 64'(py));
    tick();
    bus.valid_fe0 = 1'b0;
    @(negedge clk);
    chk("byp_count1", 64'(iq_count), 64'(1));
    tick();
    bus.decode_ready_de0 = 1'b1;
    tick();
`endif

    // Random traffic; fetch holds an unaccepted packet until taken or flushed.
    hold = 1'b0;
    tag  = 1000;
    for (int c = 0; c < 10000; c++) begin
      tick();
      nuke.valid           = ($urandom_range(0, 39) == 0);
      nuke.pc              = $urandom;
      br.valid             = ($urandom_range(0, 39) == 0);
      br.target            = $urandom;
      bus.decode_ready_de0 = 1'($urandom_range(0, 1));
      if (!hold) begin
        bus.valid_fe0 = 1'($urandom_range(0, 1));
        bus.instr_fe0 = mk(tag);
        tag++;
      end
      @(negedge clk);
      hold = bus.valid_fe0 && !bus.iq_ready_fe0 && !(nuke.valid || br.valid);
    end
    tick();
    nuke.valid           = 1'b0;
    br.valid             = 1'b0;
    bus.valid_fe0        = 1'b0;
    bus.decode_ready_de0 = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("final_count", 64'(iq_count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
